// File: rtl/cnn_conv_weight_streamer.sv
// Streams one layer's 3x3 conv weights from a synchronous weight memory into a conv top.
// Weights leave as a valid-qualified stream in memory order, so layout decides channel/tap order.
module cnn_conv_weight_streamer #(
  parameter int DATA_WIDTH      = 32,
  parameter int KERNEL          = 3,
  parameter int CHANNEL_NUM_IN  = 64,
  parameter int CHANNEL_NUM_OUT = 64,
  parameter int ADDR_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hold,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  valid_weight_out,
  output logic                  last_out,
  output logic                  busy,
  output logic                  done
);

  localparam int TOTAL = KERNEL * KERNEL * CHANNEL_NUM_IN * CHANNEL_NUM_OUT;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] emit_cnt;
  logic             drain_cnt;
  logic             rd_en_p1;

  // Hold gates reads in the same cycle, so the strobe follows hold combinationally.
  assign mem_rd_en = (state == S_STREAM) && !hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      issue_cnt <= '0;
      mem_addr  <= BASE_ADDR;
      drain_cnt <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_STREAM;
            issue_cnt <= '0;
            mem_addr  <= BASE_ADDR;
            busy      <= 1'b1;
          end
        end
        S_STREAM: begin
          if (!hold) begin
            // Address stops on the final word so it never points past the layer.
            if (issue_cnt == LAST_IDX) begin
              state     <= S_DRAIN;
              drain_cnt <= 1'b0;
            end else begin
              issue_cnt <= issue_cnt + CNT_W'(1);
              mem_addr  <= mem_addr + ADDR_WIDTH'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p1: memory data valid; stage p2: registered weight output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_en_p1         <= 1'b0;
      valid_weight_out <= 1'b0;
      weight_out       <= '0;
      last_out         <= 1'b0;
      emit_cnt         <= '0;
    end else begin
      rd_en_p1         <= mem_rd_en;
      valid_weight_out <= rd_en_p1;
      if (state == S_IDLE && start) begin
        emit_cnt <= '0;
        last_out <= 1'b0;
      end else if (rd_en_p1) begin
        weight_out <= mem_rd_data;
        last_out   <= (emit_cnt == LAST_IDX);
        emit_cnt   <= (emit_cnt == LAST_IDX) ? '0 : emit_cnt + CNT_W'(1);
      end else begin
        last_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cnn_conv_weight_streamer.sv
// Bench for cnn_conv_weight_streamer: per-cycle compare against a schedule built from hold patterns.
module tb_cnn_conv_weight_streamer;
  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int TOTAL = 36;
  localparam int MAXC  = 512;
  localparam logic [AW-1:0] BASE = 16'h0100;

  logic          clk = 1'b0;
  logic          reset, start, hold, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] weight_out;
  logic          valid_weight_out, last_out, busy, done;

  always #5 clk = ~clk;

  cnn_conv_weight_streamer #(
    .DATA_WIDTH(DW), .KERNEL(3), .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(2),
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .weight_out(weight_out), .valid_weight_out(valid_weight_out),
    .last_out(last_out), .busy(busy), .done(done)
  );

  // Synchronous memory with mem[a] = a.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= {16'h0, mem_addr};

  bit            hold_pat[MAXC];
  bit            start_pat[MAXC];
  bit            e_rd[MAXC], e_vld[MAXC], e_last[MAXC], e_busy[MAXC], e_done[MAXC];
  logic [DW-1:0] e_data[MAXC];
  logic [AW-1:0] e_addr[MAXC];

  int            n_chk = 0, n_pass = 0;
  int            cur_k;
  bit            chk_en = 1'b0;
  logic [DW-1:0] model_w = '0;
  int            beats_seen, first_vld_k, dones_seen;
  int            dc, dc2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_pats();
    for (int j = 0; j < MAXC; j++) begin
      hold_pat[j]  = 1'b0;
      start_pat[j] = 1'b0;
    end
  endtask

  // Reads happen on non-hold STREAM cycles (cycle 1 onward); data appears two cycles later.
  task automatic build_model(output int done_c);
    int idx, last_rd;
    for (int j = 0; j < MAXC; j++) begin
      e_rd[j] = 0; e_vld[j] = 0; e_last[j] = 0; e_busy[j] = 0; e_done[j] = 0;
      e_data[j] = '0; e_addr[j] = '0;
    end
    idx = 0;
    last_rd = 0;
    for (int k = 1; k < MAXC - 4 && idx < TOTAL; k++) begin
      if (!hold_pat[k]) begin
        e_rd[k]       = 1;
        e_addr[k]     = AW'(int'(BASE) + idx);
        e_vld[k+2]    = 1;
        e_data[k+2]   = DW'(int'(BASE) + idx);
        e_last[k+2]   = (idx == TOTAL - 1);
        idx++;
        last_rd = k;
      end
    end
    done_c = last_rd + 3;
    for (int j = 1; j < done_c; j++) e_busy[j] = 1;
    e_done[done_c] = 1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check($sformatf("rd_en@%0d", cur_k), mem_rd_en, e_rd[cur_k]);
      check($sformatf("valid@%0d", cur_k), valid_weight_out, e_vld[cur_k]);
      check($sformatf("last@%0d", cur_k), last_out, e_last[cur_k]);
      check($sformatf("busy@%0d", cur_k), busy, e_busy[cur_k]);
      check($sformatf("done@%0d", cur_k), done, e_done[cur_k]);
      if (e_vld[cur_k]) model_w = e_data[cur_k];
      check($sformatf("weight@%0d", cur_k), weight_out, model_w);
      if (e_rd[cur_k]) check($sformatf("addr@%0d", cur_k), mem_addr, e_addr[cur_k]);
      if (valid_weight_out) begin
        beats_seen++;
        if (first_vld_k < 0) first_vld_k = cur_k;
      end
      if (done) dones_seen++;
    end
  end

  task automatic run_layer(input int abort_k, output int done_c);
    build_model(done_c);
    beats_seen  = 0;
    first_vld_k = -1;
    dones_seen  = 0;
    for (int k = 0; k <= done_c; k++) begin
      if (k == abort_k) begin
        chk_en = 0;
        start  = 0;
        hold   = 0;
        reset  = 0;
        #2;
        check("abort_rd_en", mem_rd_en, 0);
        check("abort_valid", valid_weight_out, 0);
        check("abort_weight", weight_out, 0);
        check("abort_last", last_out, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_addr", mem_addr, BASE);
        model_w = '0;
        @(posedge clk); #1;
        reset = 1;
        return;
      end
      start  = start_pat[k];
      hold   = hold_pat[k];
      cur_k  = k;
      chk_en = 1;
      @(posedge clk); #1;
    end
    chk_en = 0;
    start  = 0;
    hold   = 0;
  endtask

  task automatic idle_check(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_valid", valid_weight_out, 0);
      check("idle_rd_en", mem_rd_en, 0);
      check("idle_done", done, 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; start = 0; hold = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, BASE);
    check("rst_valid", valid_weight_out, 0);
    check("rst_weight", weight_out, 0);
    check("rst_last", last_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    reset = 1;
    idle_check(2);

    // T1 plain stream
    clear_pats(); start_pat[0] = 1;
    run_layer(-1, dc);
    check("t1_done_cycle", dc, 39);
    check("t1_first_valid", first_vld_k, 3);
    check("t1_beats", beats_seen, TOTAL);
    check("t1_dones", dones_seen, 1);
    check("t1_hold_value", weight_out, 32'h123);
    idle_check(3);

    // T2 hold gaps of 5 and 1
    clear_pats(); start_pat[0] = 1;
    for (int j = 5; j <= 9; j++) hold_pat[j] = 1;
    hold_pat[20] = 1;
    run_layer(-1, dc);
    check("t2_done_cycle", dc, 45);
    check("t2_beats", beats_seen, TOTAL);
    idle_check(2);

    // T3 start while busy and during DONE is ignored
    clear_pats(); start_pat[0] = 1; start_pat[13] = 1; start_pat[39] = 1;
    run_layer(-1, dc);
    check("t3_beats", beats_seen, TOTAL);
    check("t3_dones", dones_seen, 1);
    idle_check(4);

    // T4 reset at beat 17, then restart from BASE
    clear_pats(); start_pat[0] = 1;
    run_layer(20, dc);
    idle_check(2);
    run_layer(-1, dc);
    check("t4_first_valid", first_vld_k, 3);
    check("t4_beats", beats_seen, TOTAL);

    // T5 back-to-back layers
    clear_pats(); start_pat[0] = 1;
    run_layer(-1, dc);
    run_layer(-1, dc2);
    check("t5_second_done_cycle", dc2, 39);
    check("t5_second_beats", beats_seen, TOTAL);
    idle_check(2);

    // T6 long hold right after start (start and hold together)
    clear_pats(); start_pat[0] = 1;
    for (int j = 0; j <= 50; j++) hold_pat[j] = 1;
    run_layer(-1, dc);
    check("t6_done_cycle", dc, 89);
    check("t6_first_valid", first_vld_k, 53);
    check("t6_beats", beats_seen, TOTAL);
    idle_check(2);

    // Randomized hold and spurious start patterns
    for (int r = 0; r < 8; r++) begin
      clear_pats();
      for (int j = 0; j < MAXC; j++) begin
        hold_pat[j]  = ($urandom_range(0, 3) == 0);
        start_pat[j] = ($urandom_range(0, 9) == 0);
      end
      start_pat[0] = 1;
      run_layer(-1, dc);
      check($sformatf("rand%0d_beats", r), beats_seen, TOTAL);
      check($sformatf("rand%0d_dones", r), dones_seen, 1);
      if ($urandom_range(0, 1) == 0) idle_check(2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
